// File: rtl/abacus_sample_controller_if.sv
// Command, configuration and status bundle between the ABACUS register
// interface (master) and the sample controller (slave).
interface abacus_sample_controller_if #(
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
);
    // Commands and configuration from the register interface
    logic             start;
    logic             abort;
    logic [CNT_W-1:0] window_cycles;
    logic [CNT_W-1:0] gap_cycles;
    logic [WIN_W-1:0] num_windows;
    logic             auto_clear;
    logic             irq_ack;

    // Controls to the profile units and status back to the registers
    logic             profile_enable;
    logic             counter_clear;
    logic             snapshot;
    logic             busy;
    logic [WIN_W-1:0] windows_done;
    logic             irq;

    modport master (
        output start, abort, window_cycles, gap_cycles, num_windows,
               auto_clear, irq_ack,
        input  profile_enable, counter_clear, snapshot, busy,
               windows_done, irq
    );

    modport slave (
        input  start, abort, window_cycles, gap_cycles, num_windows,
               auto_clear, irq_ack,
        output profile_enable, counter_clear, snapshot, busy,
               windows_done, irq
    );
endinterface

// File: rtl/abacus_sample_controller.sv
// Profiling window sequencer for the ABACUS instruction/cache profile units.
// Runs a number of fixed-length enable windows separated by optional gaps,
// pulsing a counter clear before and a snapshot strobe after each window,
// and raises a sticky interrupt when a finite sequence completes.
module abacus_sample_controller #(
    parameter int CNT_W = 32,
    parameter int WIN_W = 16
) (
    input logic                         clk,
    input logic                         rst,
    abacus_sample_controller_if.slave   ctrl
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        SNAP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [WIN_W-1:0] WIN_ONE = WIN_W'(1);

    state_t           state_q,    state_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic [CNT_W-1:0] win_len_q,  win_len_d;
    logic [CNT_W-1:0] gap_len_q,  gap_len_d;
    logic [WIN_W-1:0] num_win_q,  num_win_d;
    logic             auto_clr_q, auto_clr_d;
    logic [WIN_W-1:0] done_q,     done_d;
    logic             irq_q,      irq_d;
    logic             irq_set;
    logic [WIN_W-1:0] done_inc;

    // Registered output copies, decoded from the next state
    logic             enable_q;
    logic             clear_q;
    logic             snap_q;
    logic             busy_q;

    // Saturating completed-window count as it will be after this SNAP
    assign done_inc = (&done_q) ? done_q : done_q + WIN_ONE;

    // Next-state, counter, latched-config and interrupt decisions
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_len_d  = win_len_q;
        gap_len_d  = gap_len_q;
        num_win_d  = num_win_q;
        auto_clr_d = auto_clr_q;
        done_d     = done_q;
        irq_set    = 1'b0;

        case (state_q)
            IDLE: begin
                // abort outranks start; a zero-length window is not accepted
                if (!ctrl.abort && ctrl.start && (ctrl.window_cycles != '0)) begin
                    win_len_d  = ctrl.window_cycles;
                    gap_len_d  = ctrl.gap_cycles;
                    num_win_d  = ctrl.num_windows;
                    auto_clr_d = ctrl.auto_clear;
                    done_d     = '0;
                    if (ctrl.auto_clear) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = RUN;
                        cnt_d   = ctrl.window_cycles;
                    end
                end
            end

            CLEAR: begin
                state_d = RUN;
                cnt_d   = win_len_q;
            end

            RUN: begin
                // Counter is loaded with the window length on entry, so the
                // enable stays high for exactly that many cycles
                if (cnt_q == CNT_ONE) begin
                    state_d = SNAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            SNAP: begin
                done_d = done_inc;
                if ((num_win_q != '0) && (done_inc == num_win_q)) begin
                    state_d = IDLE;
                    irq_set = 1'b1;
                end else if (gap_len_q == '0) begin
                    if (auto_clr_q) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = RUN;
                        cnt_d   = win_len_q;
                    end
                end else begin
                    state_d = GAP;
                    cnt_d   = gap_len_q;
                end
            end

            GAP: begin
                if (cnt_q == CNT_ONE) begin
                    if (auto_clr_q) begin
                        state_d = CLEAR;
                    end else begin
                        state_d = RUN;
                        cnt_d   = win_len_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // abort from any active state: back to IDLE, count frozen, no irq
        if (ctrl.abort && (state_q != IDLE)) begin
            state_d = IDLE;
            cnt_d   = cnt_q;
            done_d  = done_q;
            irq_set = 1'b0;
        end

        // A new completion wins over a simultaneous acknowledge
        if (irq_set) begin
            irq_d = 1'b1;
        end else if (ctrl.irq_ack) begin
            irq_d = 1'b0;
        end else begin
            irq_d = irq_q;
        end
    end

    // Sequencer state, latched config, counters and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            win_len_q  <= '0;
            gap_len_q  <= '0;
            num_win_q  <= '0;
            auto_clr_q <= 1'b0;
            done_q     <= '0;
            irq_q      <= 1'b0;
            enable_q   <= 1'b0;
            clear_q    <= 1'b0;
            snap_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            win_len_q  <= win_len_d;
            gap_len_q  <= gap_len_d;
            num_win_q  <= num_win_d;
            auto_clr_q <= auto_clr_d;
            done_q     <= done_d;
            irq_q      <= irq_d;
            enable_q   <= (state_d == RUN);
            clear_q    <= (state_d == CLEAR);
            snap_q     <= (state_d == SNAP);
            busy_q     <= (state_d != IDLE);
        end
    end

    assign ctrl.profile_enable = enable_q;
    assign ctrl.counter_clear  = clear_q;
    assign ctrl.snapshot       = snap_q;
    assign ctrl.busy           = busy_q;
    assign ctrl.windows_done   = done_q;
    assign ctrl.irq            = irq_q;

endmodule

// File: tb/tb_abacus_sample_controller.sv
// Scoreboard bench for abacus_sample_controller: expected snapshots are queued
// when a sequence is started and a monitor pops one per snapshot pulse.
module tb_abacus_sample_controller;

    localparam int CNT_W = 32;
    localparam int WIN_W = 16;

    typedef struct {
        int run_len;
        int done_before;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    abacus_sample_controller_if #(.CNT_W(CNT_W), .WIN_W(WIN_W)) bus ();

    abacus_sample_controller #(.CNT_W(CNT_W), .WIN_W(WIN_W)) dut (
        .clk  (clk),
        .rst  (rst),
        .ctrl (bus)
    );

    always #5 clk = ~clk;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_exp(input int run_len, input int done_before);
        exp_t e;
        e.run_len     = run_len;
        e.done_before = done_before;
        exp_q.push_back(e);
    endtask

    task automatic do_start(input int w, input int g, input int n, input bit ac);
        bus.window_cycles = CNT_W'(w);
        bus.gap_cycles    = CNT_W'(g);
        bus.num_windows   = WIN_W'(n);
        bus.auto_clear    = ac;
        bus.start         = 1'b1;
        tick();
        bus.start         = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int limit);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (!bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, ok, 1);
    endtask

    task automatic scen1(input string tag);
        push_exp(5, 0);
        do_start(5, 0, 1, 1);
        chk({tag, "_clear_t1"}, bus.counter_clear, 1);
        chk({tag, "_en_t1"}, bus.profile_enable, 0);
        chk({tag, "_busy_t1"}, bus.busy, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk({tag, "_en_run"}, bus.profile_enable, 1);
        end
        tick();
        chk({tag, "_snap_t7"}, bus.snapshot, 1);
        chk({tag, "_en_t7"}, bus.profile_enable, 0);
        tick();
        chk({tag, "_irq_t8"}, bus.irq, 1);
        chk({tag, "_done_t8"}, bus.windows_done, 1);
        chk({tag, "_busy_t8"}, bus.busy, 0);
    endtask

    // Monitor: per-cycle exclusivity and snapshot scoreboard
    initial begin
        int   run;
        exp_t e;
        run = 0;
        forever begin
            @(negedge clk);
            chk("clear_snap_exclusive", bus.counter_clear & bus.snapshot, 0);
            chk("enable_exclusive",
                bus.profile_enable & (bus.counter_clear | bus.snapshot), 0);
            if (bus.snapshot) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_snapshot: got snapshot, expected none (done=%0d)",
                             bus.windows_done);
                end else begin
                    e = exp_q.pop_front();
                    chk("snap_run_len", run, e.run_len);
                    chk("snap_done_before", bus.windows_done, e.done_before);
                end
                run = 0;
            end else if (bus.profile_enable) begin
                run++;
            end else begin
                run = 0;
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        int  en_cnt;
        int  snap_cnt;
        int  cycles;
        bit  found;

        bus.start = 1'b0;
        bus.abort = 1'b0;
        bus.irq_ack = 1'b0;
        bus.window_cycles = '0;
        bus.gap_cycles = '0;
        bus.num_windows = '0;
        bus.auto_clear = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_enable", bus.profile_enable, 0);
        chk("rst_clear", bus.counter_clear, 0);
        chk("rst_snap", bus.snapshot, 0);
        chk("rst_irq", bus.irq, 0);
        chk("rst_done", bus.windows_done, 0);
        rst = 1'b0;
        tick();

        // Single auto-clear window
        scen1("s1");

        // Three windows with gaps, no auto-clear
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        chk("s2_irq_acked", bus.irq, 0);
        push_exp(3, 0);
        push_exp(3, 1);
        push_exp(3, 2);
        do_start(3, 2, 3, 0);
        en_cnt = 0;
        snap_cnt = 0;
        cycles = 0;
        for (int i = 0; i < 60 && bus.busy; i++) begin
            en_cnt += int'(bus.profile_enable);
            snap_cnt += int'(bus.snapshot);
            chk("s2_no_clear", bus.counter_clear, 0);
            cycles++;
            tick();
        end
        chk("s2_idle", bus.busy, 0);
        chk("s2_busy_cycles", cycles, 16);
        chk("s2_enable_cycles", en_cnt, 9);
        chk("s2_snapshots", snap_cnt, 3);
        chk("s2_done", bus.windows_done, 3);
        chk("s2_irq", bus.irq, 1);

        // Continuous mode, abort in the 4th window
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        push_exp(2, 0);
        push_exp(2, 1);
        push_exp(2, 2);
        do_start(2, 0, 0, 0);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.windows_done == 3 && bus.profile_enable) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("s3_reach_4th_run", found, 1);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("s3_busy", bus.busy, 0);
        chk("s3_enable", bus.profile_enable, 0);
        chk("s3_done", bus.windows_done, 3);
        chk("s3_irq", bus.irq, 0);
        repeat (4) tick();
        chk("s3_still_idle", bus.busy, 0);

        // Zero-length start ignored
        do_start(0, 1, 1, 1);
        chk("s4_zero_busy", bus.busy, 0);
        chk("s4_zero_clear", bus.counter_clear, 0);
        chk("s4_zero_done", bus.windows_done, 3);
        chk("s4_zero_irq", bus.irq, 0);

        // start and abort together in IDLE
        bus.window_cycles = 4;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("s4_abort_busy", bus.busy, 0);
        chk("s4_abort_done", bus.windows_done, 3);

        // start while running is ignored
        push_exp(4, 0);
        do_start(4, 0, 1, 0);
        chk("s4_run_enable", bus.profile_enable, 1);
        chk("s4_run_done_cleared", bus.windows_done, 0);
        bus.window_cycles = 9;
        bus.num_windows = 5;
        bus.auto_clear = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("s4_run_enable2", bus.profile_enable, 1);
        wait_idle("s4_run_finish", 20);
        chk("s4_run_done", bus.windows_done, 1);
        chk("s4_run_irq", bus.irq, 1);

        // Completion and acknowledge in the same cycle
        push_exp(2, 0);
        do_start(2, 0, 1, 0);
        found = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.snapshot) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("s5_reach_snap", found, 1);
        bus.irq_ack = 1'b1;
        tick();
        chk("s5_irq_set_wins", bus.irq, 1);
        chk("s5_busy", bus.busy, 0);
        chk("s5_done", bus.windows_done, 1);
        tick();
        bus.irq_ack = 1'b0;
        chk("s5_irq_acked", bus.irq, 0);

        // Reset in the middle of a window
        do_start(6, 0, 0, 1);
        tick();
        tick();
        chk("s6_running", bus.profile_enable, 1);
        rst = 1'b1;
        tick();
        chk("s6_rst_enable", bus.profile_enable, 0);
        chk("s6_rst_busy", bus.busy, 0);
        chk("s6_rst_snap", bus.snapshot, 0);
        chk("s6_rst_clear", bus.counter_clear, 0);
        chk("s6_rst_done", bus.windows_done, 0);
        chk("s6_rst_irq", bus.irq, 0);
        rst = 1'b0;
        tick();
        scen1("s6");

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
